direct_mapped_cache_ctrl: RTL and testbench

//  Sequencing controller plus tag/valid/data storage for a direct-mapped, one-word-per-line cache.

---
 rtl/direct_mapped_cache_ctrl_if.sv | 33 +++
 rtl/direct_mapped_cache_ctrl.sv | 152 +++++++++++++++
 tb/tb_direct_mapped_cache_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/direct_mapped_cache_ctrl_if.sv
// CPU request/response and main-memory request bundle for direct_mapped_cache_ctrl.
// The slave modport is the cache's view; master is the CPU/memory side.
interface direct_mapped_cache_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_hit;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_hit,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_hit,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/direct_mapped_cache_ctrl.sv
// Direct-mapped, one-word-per-line, write-through/write-allocate cache controller with storage.
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module direct_mapped_cache_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned INDEX_WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
`ifdef CACHE_STATS_EN
  output logic [15:0] hit_count,
  output logic [15:0] miss_count,
`endif
  direct_mapped_cache_ctrl_if.slave bus
);
  localparam int unsigned TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;
  localparam int unsigned LINES     = 1 << INDEX_WIDTH;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WTHRU, RESP} state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   write_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic                   hit_q;
  logic [LINES-1:0]       valid_q;
  logic [TAG_WIDTH-1:0]   tag_mem  [LINES];
  logic [DATA_WIDTH-1:0]  data_mem [LINES];

  logic [INDEX_WIDTH-1:0] idx_c;
  logic [TAG_WIDTH-1:0]   tag_c;
  logic                   hit_c;
  logic                   fill_c;
  logic [DATA_WIDTH-1:0]  fill_data_c;

  assign idx_c = addr_q[INDEX_WIDTH-1:0];
  assign tag_c = addr_q[ADDR_WIDTH-1:INDEX_WIDTH];
  assign hit_c = valid_q[idx_c] && (tag_mem[idx_c] == tag_c);

  // A line is (re)installed by any write in LOOKUP or by refill data on mem_ack.
  always_comb begin
    fill_c      = 1'b0;
    fill_data_c = wdata_q;
    if (state == LOOKUP && write_q) begin
      fill_c = 1'b1;
    end else if (state == REFILL && bus.mem_ack) begin
      fill_c      = 1'b1;
      fill_data_c = bus.mem_rdata;
    end
  end

  // Tag/data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_c) begin
      tag_mem[idx_c]  <= tag_c;
      data_mem[idx_c] <= fill_data_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      valid_q        <= '0;
      addr_q         <= '0;
      write_q        <= 1'b0;
      wdata_q        <= '0;
      hit_q          <= 1'b0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_hit   <= 1'b0;
      bus.resp_rdata <= '0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      if (fill_c) valid_q[idx_c] <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q        <= bus.req_addr;
            write_q       <= bus.req_write;
            wdata_q       <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            state         <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (write_q) begin
            hit_q         <= hit_c;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= addr_q;
            bus.mem_wdata <= wdata_q;
            state         <= WTHRU;
          end else if (hit_c) begin
            bus.resp_valid <= 1'b1;
            bus.resp_hit   <= 1'b1;
            bus.resp_rdata <= data_mem[idx_c];
            state          <= RESP;
          end else begin
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= addr_q;
            state        <= REFILL;
          end
        end
        REFILL: begin
          if (bus.mem_ack) begin
            bus.mem_req    <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_hit   <= 1'b0;
            bus.resp_rdata <= bus.mem_rdata;
            state          <= RESP;
          end
        end
        WTHRU: begin
          if (bus.mem_ack) begin
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_hit   <= hit_q;
            bus.resp_rdata <= wdata_q;
            state          <= RESP;
          end
        end
        RESP: begin
          bus.resp_valid <= 1'b0;
          bus.req_ready  <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // Each request is classified once, in LOOKUP; counters saturate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (hit_c) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'(1);
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'(1);
      end
    end
  end
`endif
endmodule

// File: tb/tb_direct_mapped_cache_ctrl.sv
// Directed bench for direct_mapped_cache_ctrl: cache-content model keyed by line index,
// one negedge monitor comparing the bus against the current expected transaction.
module tb_direct_mapped_cache_ctrl;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  direct_mapped_cache_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  direct_mapped_cache_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef CACHE_STATS_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .bus        (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: which full address each line index currently holds, and its data.
  logic [AW-1:0] line_addr [int];
  logic [DW-1:0] line_data [int];
  int model_hits = 0;
  int model_misses = 0;

  // Expectation for the transaction in flight.
  bit          busy = 1'b0;
  bit          exp_need_mem = 1'b0;
  bit          exp_we = 1'b0;
  bit          exp_hit = 1'b0;
  logic [AW-1:0] exp_maddr = '0;
  logic [DW-1:0] exp_mwdata = '0;
  logic [DW-1:0] exp_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("req_ready", 32'(bus.req_ready), 32'(!busy));
      if (bus.mem_req) begin
        check("mem_req_expected", 32'(busy && exp_need_mem), 32'd1);
        check("mem_we", 32'(bus.mem_we), 32'(exp_we));
        check("mem_addr", 32'(bus.mem_addr), 32'(exp_maddr));
        if (exp_we) check("mem_wdata", 32'(bus.mem_wdata), 32'(exp_mwdata));
      end
      if (bus.resp_valid) begin
        check("resp_expected", 32'(busy), 32'd1);
        check("resp_rdata", 32'(bus.resp_rdata), 32'(exp_rdata));
        check("resp_hit", 32'(bus.resp_hit), 32'(exp_hit));
      end
    end
  end

  function automatic bit model_is_hit(input logic [AW-1:0] addr);
    int idx;
    idx = int'(addr % 16);
    if (line_addr.exists(idx)) return line_addr[idx] == addr;
    return 1'b0;
  endfunction

  task automatic present(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1;
    busy          = 1'b1;
    bus.req_valid = 1'b0;
  endtask

  task automatic do_req(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int ack_delay, input logic [DW-1:0] mdata,
                        input bit lit_hit, input logic [DW-1:0] lit_rdata, input bit poke);
    bit mhit;
    bit got;
    bit acked;
    int idx;
    int lat;
    int memwait;
    int mreq_cycles;
    idx  = int'(addr % 16);
    mhit = model_is_hit(addr);
    exp_hit      = mhit;
    exp_need_mem = wr || !mhit;
    exp_we       = wr;
    exp_maddr    = addr;
    exp_mwdata   = wdata;
    exp_rdata    = wr ? wdata : (mhit ? line_data[idx] : mdata);
    check("model_hit_pin", 32'(mhit), 32'(lit_hit));
    check("model_rdata_pin", 32'(exp_rdata), 32'(lit_rdata));

    present(wr, addr, wdata);
    got = 1'b0; acked = 1'b0; lat = 0; memwait = 0; mreq_cycles = 0;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      @(negedge clk);
      if (bus.mem_ack) bus.mem_ack = 1'b0;
      if (bus.mem_req) mreq_cycles++;
      if (bus.resp_valid) begin
        got = 1'b1;
        lat = cyc;
        check("resp_rdata_lit", 32'(bus.resp_rdata), 32'(lit_rdata));
      end else if (bus.mem_req && !acked) begin
        if (memwait == ack_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mdata;
          acked         = 1'b1;
          bus.req_valid = 1'b0;
        end else begin
          memwait++;
          if (poke) begin
            bus.req_valid = 1'b1;
            bus.req_write = 1'b1;
            bus.req_addr  = 16'h9990;
            bus.req_wdata = 16'hDEAD;
          end
        end
      end
    end
    bus.mem_ack   = 1'b0;
    bus.req_valid = 1'b0;
    check("resp_timeout", 32'(got), 32'd1);
    check("latency", 32'(lat), exp_need_mem ? 32'(3 + ack_delay) : 32'd2);
    check("mem_req_cycles", 32'(mreq_cycles), exp_need_mem ? 32'(ack_delay + 1) : 32'd0);
    @(posedge clk);
    #1;
    busy = 1'b0;
    if (exp_need_mem) begin
      line_addr[idx] = addr;
      line_data[idx] = wr ? wdata : mdata;
    end
    if (mhit) model_hits++;
    else model_misses++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp", {29'd0, bus.resp_valid, bus.resp_hit, bus.mem_req}, 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_data", {bus.resp_rdata, bus.mem_addr}, 32'd0);
    check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Cold miss, warm hit, write-allocate eviction, refill after eviction
    do_req(1'b0, 16'h1234, 16'h0000, 0, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0);
    do_req(1'b0, 16'h1234, 16'h0000, 0, 16'h0000, 1'b1, 16'hBEEF, 1'b0);
    do_req(1'b1, 16'h5674, 16'hAAAA, 0, 16'h0000, 1'b0, 16'hAAAA, 1'b0);
    do_req(1'b0, 16'h5674, 16'h0000, 0, 16'h0000, 1'b1, 16'hAAAA, 1'b0);
    do_req(1'b0, 16'h1234, 16'h0000, 0, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0);
`ifdef CACHE_STATS_EN
    check("hit_count", 32'(hit_count), 32'd2);
    check("miss_count", 32'(miss_count), 32'd3);
    check("hit_count_model", 32'(hit_count), 32'(model_hits));
`endif

    // Write hit with a slow memory, then read back the written word
    do_req(1'b1, 16'h1234, 16'h7777, 1, 16'h0000, 1'b1, 16'h7777, 1'b0);
    do_req(1'b0, 16'h1234, 16'h0000, 0, 16'h0000, 1'b1, 16'h7777, 1'b0);

    // Delayed ack with a competing request that must be ignored
    do_req(1'b0, 16'h00A0, 16'h0000, 5, 16'h0F0F, 1'b0, 16'h0F0F, 1'b1);
    repeat (3) @(negedge clk);
    do_req(1'b0, 16'h00A0, 16'h0000, 0, 16'h0000, 1'b1, 16'h0F0F, 1'b0);

    // Reset during a refill
    exp_need_mem = 1'b1; exp_we = 1'b0; exp_maddr = 16'h0037; exp_hit = 1'b0;
    present(1'b0, 16'h0037, 16'h0000);
    seen = 1'b0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge clk);
      seen = bus.mem_req;
    end
    check("refill_started", 32'(seen), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    busy = 1'b0;
    line_addr.delete();
    line_data.delete();
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      check("rst_mid_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    do_req(1'b0, 16'h1234, 16'h0000, 0, 16'h4321, 1'b0, 16'h4321, 1'b0);
`ifdef CACHE_STATS_EN
    check("miss_after_reset", 32'(miss_count), 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
